// File: rtl/path_sequencer_if.sv
// path_sequencer_if
//   Node stream handshake between the path sequencer (master) and the bot
//   navigation controller (slave).
//   node_data  : current node ID
//   node_idx   : 0-based position of node_data in the path
//   node_last  : high with node_valid on the final node of the path
//   node_valid : node_data/node_idx/node_last are valid
//   node_ready : consumer accepts the current node
interface path_sequencer_if #(
  parameter int NODE_W = 8,
  parameter int IDX_W  = 5
);
  logic [NODE_W-1:0] node_data;
  logic [IDX_W-1:0]  node_idx;
  logic              node_last;
  logic              node_valid;
  logic              node_ready;

  modport master (
    output node_data,
    output node_idx,
    output node_last,
    output node_valid,
    input  node_ready
  );

  modport slave (
    input  node_data,
    input  node_idx,
    input  node_last,
    input  node_valid,
    output node_ready
  );
endinterface

// File: rtl/path_sequencer.sv
// path_sequencer
//   Snapshots the CPU shortest-path result on the rising edge of cpu_done and
//   streams it node by node to the navigation controller.
//   clk_50M     : system clock
//   reset       : asynchronous active-high reset
//   cpu_reset   : CPU held in reset, results stale
//   cpu_done    : CPU finished (level, held until next cpu_reset)
//   path_flat   : node i at [i*NODE_W +: NODE_W]
//   path_size   : number of valid nodes reported by the CPU
//   node        : master side of the node stream handshake
//   busy        : streaming a captured path
//   path_done   : one-cycle pulse after the final node (or an empty capture)
//   size_err    : sticky, path_size exceeded MAX_NODES at capture
//   overrun     : sticky, capture edge arrived while streaming
//   clear_flags : synchronous clear of size_err/overrun (wins over a set)
module path_sequencer #(
  parameter int MAX_NODES = 13,
  parameter int NODE_W    = 8,
  parameter int IDX_W     = 5
) (
  input  logic                          clk_50M,
  input  logic                          reset,
  input  logic                          cpu_reset,
  input  logic                          cpu_done,
  input  logic [MAX_NODES*NODE_W-1:0]   path_flat,
  input  logic [IDX_W-1:0]              path_size,
  path_sequencer_if.master              node,
  output logic                          busy,
  output logic                          path_done,
  output logic                          size_err,
  output logic                          overrun,
  input  logic                          clear_flags
);

  localparam int BUF_AW = $clog2(MAX_NODES);
  localparam logic [IDX_W-1:0] MAX_SIZE = IDX_W'(MAX_NODES);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t            state_reg;
  logic [NODE_W-1:0] buffer_reg [MAX_NODES];
  logic [IDX_W-1:0]  stored_size_reg;
  logic              done_q_reg;
  logic [NODE_W-1:0] node_data_reg;
  logic [IDX_W-1:0]  node_idx_reg;
  logic              node_last_reg;
  logic              node_valid_reg;
  logic              busy_reg;
  logic              path_done_reg;
  logic              size_err_reg;
  logic              overrun_reg;

  logic [NODE_W-1:0] path_nodes [MAX_NODES];
  logic              cap_evt;
  logic              oversize;
  logic              xfer;
  logic [IDX_W-1:0]  capture_size;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  after_idx;
  logic [BUF_AW-1:0] rd_addr;

  // Unpack the flat CPU bus into an array of node IDs.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_unpack
    assign path_nodes[gi] = path_flat[gi*NODE_W +: NODE_W];
  end

  assign cap_evt      = cpu_done & ~done_q_reg & ~cpu_reset;
  assign oversize     = path_size > MAX_SIZE;
  assign capture_size = oversize ? MAX_SIZE : path_size;
  assign xfer         = node_valid_reg & node.node_ready;
  assign next_idx     = node_idx_reg + IDX_ONE;
  assign after_idx    = node_idx_reg + IDX_TWO;
  // Read address comes only from the registered index, so node_data is a
  // buffer read, never a path from path_flat once the snapshot is taken.
  assign rd_addr      = next_idx[BUF_AW-1:0];

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      for (int i = 0; i < MAX_NODES; i++) buffer_reg[i] <= '0;
      stored_size_reg <= '0;
      // Start "already seen high" so a level cpu_done at reset release is
      // not mistaken for a fresh completion.
      done_q_reg      <= 1'b1;
      node_data_reg   <= '0;
      node_idx_reg    <= '0;
      node_last_reg   <= 1'b0;
      node_valid_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      path_done_reg   <= 1'b0;
      size_err_reg    <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      // Holding done_q low during cpu_reset guarantees one event per run.
      done_q_reg    <= cpu_reset ? 1'b0 : cpu_done;
      path_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cap_evt) begin
            for (int i = 0; i < MAX_NODES; i++) buffer_reg[i] <= path_nodes[i];
            stored_size_reg <= capture_size;
            if (capture_size != '0) begin
              state_reg      <= STREAM;
              node_valid_reg <= 1'b1;
              node_idx_reg   <= '0;
              node_data_reg  <= path_nodes[0];
              node_last_reg  <= (capture_size == IDX_ONE);
              busy_reg       <= 1'b1;
            end else begin
              // Empty path: report completion without ever raising valid.
              path_done_reg <= 1'b1;
            end
          end
        end
        STREAM: begin
          // A capture edge here is an overrun; the snapshot is left untouched.
          if (xfer) begin
            if (node_last_reg) begin
              state_reg      <= IDLE;
              node_valid_reg <= 1'b0;
              node_last_reg  <= 1'b0;
              busy_reg       <= 1'b0;
              path_done_reg  <= 1'b1;
            end else begin
              node_idx_reg  <= next_idx;
              node_data_reg <= buffer_reg[rd_addr];
              node_last_reg <= (after_idx == stored_size_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (clear_flags) begin
        size_err_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end else begin
        if (state_reg == IDLE && cap_evt && oversize) size_err_reg <= 1'b1;
        if (state_reg == STREAM && cap_evt)           overrun_reg  <= 1'b1;
      end
    end
  end

  assign node.node_data  = node_data_reg;
  assign node.node_idx   = node_idx_reg;
  assign node.node_last  = node_last_reg;
  assign node.node_valid = node_valid_reg;
  assign busy            = busy_reg;
  assign path_done       = path_done_reg;
  assign size_err        = size_err_reg;
  assign overrun         = overrun_reg;

endmodule

// File: tb/tb_path_sequencer.sv
// tb_path_sequencer
//   Scoreboard bench: each run pushes the expected node list when the CPU
//   result is driven; observed transfers are popped against it.
module tb_path_sequencer;

  localparam int MAX_NODES = 13;
  localparam int NODE_W    = 8;
  localparam int IDX_W     = 5;

  logic                        clk_50M;
  logic                        reset;
  logic                        cpu_reset;
  logic                        cpu_done;
  logic [MAX_NODES*NODE_W-1:0] path_flat;
  logic [IDX_W-1:0]            path_size;
  logic                        busy;
  logic                        path_done;
  logic                        size_err;
  logic                        overrun;
  logic                        clear_flags;

  path_sequencer_if #(.NODE_W(NODE_W), .IDX_W(IDX_W)) node_bus ();

  path_sequencer #(.MAX_NODES(MAX_NODES), .NODE_W(NODE_W), .IDX_W(IDX_W)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .cpu_reset   (cpu_reset),
    .cpu_done    (cpu_done),
    .path_flat   (path_flat),
    .path_size   (path_size),
    .node        (node_bus.master),
    .busy        (busy),
    .path_done   (path_done),
    .size_err    (size_err),
    .overrun     (overrun),
    .clear_flags (clear_flags)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [NODE_W-1:0] stim_nodes [MAX_NODES];
  logic [NODE_W-1:0] exp_q [$];
  logic [NODE_W-1:0] obs_data [$];
  logic [IDX_W-1:0]  obs_idx [$];
  bit                obs_last [$];
  int done_cnt, busy_cnt, stall_viol, valid_seen, done_cyc, last_xfer_cyc;
  bit timeout;

  // Drive a CPU run (cpu_reset pulse, result, cpu_done rise) and push the
  // expected stream: first min(size, MAX_NODES) nodes.
  task automatic start_run(input int size);
    int n;
    @(negedge clk_50M);
    cpu_done  = 1'b0;
    cpu_reset = 1'b1;
    path_flat = '0;
    for (int i = 0; i < MAX_NODES; i++) path_flat[i*NODE_W +: NODE_W] = stim_nodes[i];
    path_size = IDX_W'(size);
    exp_q.delete();
    n = (size > MAX_NODES) ? MAX_NODES : size;
    for (int i = 0; i < n; i++) exp_q.push_back(stim_nodes[i]);
    @(negedge clk_50M);
    cpu_reset = 1'b0;
    @(negedge clk_50M);
    cpu_done = 1'b1;
  endtask

  // Observe the stream for up to max_cyc cycles with a repeating ready
  // pattern; records transfers and handshake statistics (no judging here).
  task automatic collect(input logic [31:0] pat, input int plen, input int max_cyc,
                         input bit stop_on_done);
    bit held;
    logic [NODE_W-1:0] h_data;
    logic [IDX_W-1:0]  h_idx;
    logic              h_last;
    obs_data.delete(); obs_idx.delete(); obs_last.delete();
    done_cnt = 0; busy_cnt = 0; stall_viol = 0; valid_seen = 0;
    done_cyc = -1; last_xfer_cyc = -1; held = 1'b0;
    h_data = '0; h_idx = '0; h_last = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_50M);
      node_bus.node_ready = pat[c % plen];
      if (held && (!node_bus.node_valid || node_bus.node_data !== h_data ||
                   node_bus.node_idx !== h_idx || node_bus.node_last !== h_last))
        stall_viol++;
      if (node_bus.node_valid) valid_seen++;
      if (busy) busy_cnt++;
      if (path_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (node_bus.node_valid && node_bus.node_ready) begin
        obs_data.push_back(node_bus.node_data);
        obs_idx.push_back(node_bus.node_idx);
        obs_last.push_back(node_bus.node_last);
        last_xfer_cyc = c;
        $display("[%0t] xfer idx=%0d data=%0d last=%0b", $time,
                 node_bus.node_idx, node_bus.node_data, node_bus.node_last);
      end
      held   = node_bus.node_valid && !node_bus.node_ready;
      h_data = node_bus.node_data;
      h_idx  = node_bus.node_idx;
      h_last = node_bus.node_last;
      if (stop_on_done && done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    timeout = (done_cyc < 0);
    node_bus.node_ready = 1'b0;
  endtask

  task automatic test_reset();
    cpu_done = 1'b1;
    #5;
    n_checks++;
    if ({node_bus.node_valid, node_bus.node_last, busy, path_done, size_err, overrun} !== 6'b0 ||
        node_bus.node_data !== '0 || node_bus.node_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b data=%0d idx=%0d busy=%0b, required all 0",
               node_bus.node_valid, node_bus.node_data, node_bus.node_idx, busy);
    end
    @(negedge clk_50M);
    reset = 1'b0;
    repeat (3) @(negedge clk_50M);
    n_checks++;
    if (node_bus.node_valid !== 1'b0 || busy !== 1'b0 || path_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_no_capture: valid=%0b busy=%0b done=%0b, required 0",
               node_bus.node_valid, busy, path_done);
    end
  endtask

  task automatic test_full_ready();
    int n;
    stim_nodes = '{default: 8'hEE};
    stim_nodes[0] = 0; stim_nodes[1] = 3; stim_nodes[2] = 6; stim_nodes[3] = 7;
    start_run(4);
    collect(32'h1, 1, 50, 1'b1);
    n = exp_q.size();
    n_checks++;
    if (timeout || obs_data.size() != n) begin
      n_fail++;
      $display("FAIL full_count: got %0d nodes timeout=%0b, required %0d", obs_data.size(), timeout, n);
    end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      logic [NODE_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_data[i] !== e || obs_idx[i] !== IDX_W'(i) || obs_last[i] !== (i == n-1)) begin
        n_fail++;
        $display("FAIL full_node%0d: data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                 i, obs_data[i], obs_idx[i], obs_last[i], e, i, (i == n-1));
      end
    end
    n_checks++;
    if (last_xfer_cyc != n-1) begin
      n_fail++;
      $display("FAIL full_zero_bubble: last transfer in cycle %0d, required %0d", last_xfer_cyc, n-1);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1) begin
      n_fail++;
      $display("FAIL full_path_done: pulses=%0d at %0d, required 1 at %0d", done_cnt, done_cyc, last_xfer_cyc + 1);
    end
    n_checks++;
    if (busy_cnt != 4) begin
      n_fail++;
      $display("FAIL full_busy_cycles: got %0d, required 4", busy_cnt);
    end
  endtask

  task automatic test_stall();
    int n;
    stim_nodes = '{default: 8'hEE};
    stim_nodes[0] = 0; stim_nodes[1] = 3; stim_nodes[2] = 6; stim_nodes[3] = 7;
    start_run(4);
    // ready sequence 1,0,0,1,0,1,1 (bit c of the pattern is used in cycle c)
    collect(32'b1101001, 7, 50, 1'b1);
    n = exp_q.size();
    n_checks++;
    if (timeout || obs_data.size() != n) begin
      n_fail++;
      $display("FAIL stall_count: got %0d nodes timeout=%0b, required %0d", obs_data.size(), timeout, n);
    end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      logic [NODE_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_data[i] !== e || obs_idx[i] !== IDX_W'(i)) begin
        n_fail++;
        $display("FAIL stall_node%0d: data=%0d idx=%0d, required data=%0d idx=%0d",
                 i, obs_data[i], obs_idx[i], e, i);
      end
    end
    n_checks++;
    if (stall_viol != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL stall_hold: violations=%0d done_pulses=%0d, required 0 and 1", stall_viol, done_cnt);
    end
  endtask

  task automatic test_zero_size();
    stim_nodes = '{default: 8'h11};
    start_run(0);
    collect(32'h1, 1, 20, 1'b1);
    n_checks++;
    if (valid_seen != 0 || done_cyc != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_size: valid_cycles=%0d done_cycle=%0d pulses=%0d, required 0, 0, 1",
               valid_seen, done_cyc, done_cnt);
    end
    n_checks++;
    if (size_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_size_err: got %0b, required 0", size_err);
    end
  endtask

  task automatic test_oversize();
    int n;
    for (int i = 0; i < MAX_NODES; i++) stim_nodes[i] = NODE_W'(100 + 3*i);
    start_run(20);
    collect(32'h1, 1, 60, 1'b1);
    n = exp_q.size();
    n_checks++;
    if (timeout || obs_data.size() != MAX_NODES) begin
      n_fail++;
      $display("FAIL over_count: got %0d nodes timeout=%0b, required %0d", obs_data.size(), timeout, MAX_NODES);
    end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      logic [NODE_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_data[i] !== e || obs_last[i] !== (i == n-1)) begin
        n_fail++;
        $display("FAIL over_node%0d: data=%0d last=%0b, required data=%0d last=%0b",
                 i, obs_data[i], obs_last[i], e, (i == n-1));
      end
    end
    n_checks++;
    if (size_err !== 1'b1) begin
      n_fail++;
      $display("FAIL over_size_err: got %0b, required 1", size_err);
    end
    @(negedge clk_50M); clear_flags = 1'b1;
    @(negedge clk_50M); clear_flags = 1'b0;
    n_checks++;
    if (size_err !== 1'b0) begin
      n_fail++;
      $display("FAIL over_clear: got %0b, required 0", size_err);
    end
  endtask

  task automatic test_held_done();
    int first_caps;
    stim_nodes = '{default: 8'h00};
    stim_nodes[0] = 40; stim_nodes[1] = 41;
    start_run(2);
    collect(32'h1, 1, 1000, 1'b0);
    first_caps = done_cnt;
    n_checks++;
    if (obs_data.size() != 2 || obs_data[0] !== exp_q[0] || obs_data[1] !== exp_q[1]) begin
      n_fail++;
      $display("FAIL held_first_stream: got %0d nodes, required exactly 2 (40,41)", obs_data.size());
    end
    for (int i = 0; i < MAX_NODES; i++) stim_nodes[i] = (i < 9) ? NODE_W'(5 + 2*i) : 8'hEE;
    start_run(9);
    collect(32'h1, 1, 60, 1'b1);
    n_checks++;
    if (first_caps + done_cnt != 2) begin
      n_fail++;
      $display("FAIL held_captures: got %0d, required 2", first_caps + done_cnt);
    end
    n_checks++;
    if (obs_data.size() != exp_q.size() || obs_data.size() == 0 || obs_data[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL held_second_start: got %0d nodes first=%0d, required 9 first=5",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 8'hxx);
    end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      logic [NODE_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_data[i] !== e) begin
        n_fail++;
        $display("FAIL held_node%0d: data=%0d, required %0d", i, obs_data[i], e);
      end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < MAX_NODES; i++) stim_nodes[i] = NODE_W'(10 + i);
    start_run(6);
    fork
      collect(32'h1, 2, 60, 1'b1);
      begin
        // New CPU run while the first path is still streaming.
        repeat (2) @(negedge clk_50M);
        cpu_done  = 1'b0;
        cpu_reset = 1'b1;
        path_flat = '1;
        path_size = IDX_W'(3);
        @(negedge clk_50M);
        cpu_reset = 1'b0;
        @(negedge clk_50M);
        cpu_done = 1'b1;
      end
    join
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %0b, required 1", overrun);
    end
    n_checks++;
    if (timeout || obs_data.size() != exp_q.size() || done_cnt != 1) begin
      n_fail++;
      $display("FAIL overrun_stream: got %0d nodes %0d pulses, required %0d nodes 1 pulse",
               obs_data.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      logic [NODE_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_data[i] !== e || obs_idx[i] !== IDX_W'(i)) begin
        n_fail++;
        $display("FAIL overrun_node%0d: data=%0d idx=%0d, required data=%0d idx=%0d",
                 i, obs_data[i], obs_idx[i], e, i);
      end
    end
    @(negedge clk_50M); clear_flags = 1'b1;
    @(negedge clk_50M); clear_flags = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %0b, required 0", overrun);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < MAX_NODES; i++) stim_nodes[i] = NODE_W'(200 + i);
    node_bus.node_ready = 1'b0;
    start_run(20);
    repeat (3) @(negedge clk_50M);
    n_checks++;
    if (node_bus.node_valid !== 1'b1 || busy !== 1'b1 || size_err !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: valid=%0b busy=%0b size_err=%0b, required 1 1 1",
               node_bus.node_valid, busy, size_err);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({node_bus.node_valid, node_bus.node_last, busy, path_done, size_err, overrun} !== 6'b0 ||
        node_bus.node_data !== '0 || node_bus.node_idx !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: valid=%0b data=%0d busy=%0b size_err=%0b, required all 0",
               node_bus.node_valid, node_bus.node_data, busy, size_err);
    end
    @(negedge clk_50M);
    reset = 1'b0;
    repeat (3) @(negedge clk_50M);
    n_checks++;
    if (node_bus.node_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_no_recapture: valid=%0b busy=%0b, required 0 0", node_bus.node_valid, busy);
    end
  endtask

  initial begin
    reset               = 1'b1;
    cpu_reset           = 1'b0;
    cpu_done            = 1'b0;
    path_flat           = '0;
    path_size           = '0;
    clear_flags         = 1'b0;
    node_bus.node_ready = 1'b0;
    test_reset();
    test_full_ready();
    test_stall();
    test_zero_size();
    test_oversize();
    test_held_done();
    test_overrun();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
